// File: rtl/multi_tick_gen.sv
// Multi-channel periodic / one-shot tick generator. Every channel owns its own
// period, mode, counter and one-shot state; all share one config write port.
module multi_tick_gen #(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = 2,
  parameter int CNT_WIDTH      = 25,
  parameter int DEFAULT_PERIOD = 10000000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_CH-1:0]    EN,
  input  logic [NUM_CH-1:0]    START,
  input  logic                 SYNC,
  input  logic                 CFG_WE,
  input  logic [CH_W-1:0]      CFG_CH,
  input  logic [CNT_WIDTH-1:0] CFG_PERIOD,
  input  logic                 CFG_ONESHOT,
  output logic [NUM_CH-1:0]    TICK,
  output logic [NUM_CH-1:0]    BUSY
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  // Out-of-range channel indices never reach any channel.
  logic cfg_valid_s;
  assign cfg_valid_s = CFG_WE && (32'(CFG_CH) < 32'(NUM_CH));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] period_r;
    logic [CNT_WIDTH-1:0] period_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_s;
    logic                 oneshot_r;
    logic                 oneshot_s;
    logic                 tick_r;
    logic                 tick_s;
    logic                 busy_r;
    state_t               state_r;
    state_t               state_s;
    logic                 cfg_hit_s;
    logic                 last_s;
    logic                 period_zero_s;

    assign cfg_hit_s     = cfg_valid_s && (CFG_CH == CH_W'(i));
    assign period_zero_s = (period_r == CNT_ZERO);
    assign last_s        = (cnt_r == (period_r - CNT_ONE));

    // Next-state: config write > disable > SYNC > START > normal count.
    always_comb begin
      period_s  = period_r;
      oneshot_s = oneshot_r;
      cnt_s     = cnt_r;
      state_s   = state_r;
      tick_s    = 1'b0;
      if (cfg_hit_s) begin
        period_s  = CFG_PERIOD;
        oneshot_s = CFG_ONESHOT;
        cnt_s     = CNT_ZERO;
        state_s   = ST_IDLE;
      end else if (!EN[i]) begin
        cnt_s   = CNT_ZERO;
        state_s = ST_IDLE;
      end else if (SYNC) begin
        cnt_s = CNT_ZERO;
      end else if (period_zero_s) begin
        cnt_s   = CNT_ZERO;
        state_s = ST_IDLE;
      end else if (!oneshot_r) begin
        if (last_s) begin
          cnt_s  = CNT_ZERO;
          tick_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            cnt_s = CNT_ZERO;
            if (START[i]) begin
              state_s = ST_RUN;
            end else begin
              state_s = ST_IDLE;
            end
          end
          ST_RUN: begin
            if (last_s) begin
              cnt_s   = CNT_ZERO;
              tick_s  = 1'b1;
              state_s = ST_IDLE;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end
          default: begin
            cnt_s   = CNT_ZERO;
            state_s = ST_IDLE;
          end
        endcase
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        period_r  <= RST_PERIOD;
        oneshot_r <= 1'b0;
        cnt_r     <= CNT_ZERO;
        state_r   <= ST_IDLE;
        tick_r    <= 1'b0;
        busy_r    <= 1'b0;
      end else begin
        period_r  <= period_s;
        oneshot_r <= oneshot_s;
        cnt_r     <= cnt_s;
        state_r   <= state_s;
        tick_r    <= tick_s;
        busy_r    <= (state_s == ST_RUN);
      end
    end

    assign TICK[i] = tick_r;
    assign BUSY[i] = busy_r;
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Bench for multi_tick_gen: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an edge-counting model.
module tb_multi_tick_gen;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 3;
  localparam int CW     = 16;
  localparam int DEF    = 10;

  logic              CLK;
  logic              RESET;
  logic [NUM_CH-1:0] EN;
  logic [NUM_CH-1:0] START;
  logic              SYNC;
  logic              CFG_WE;
  logic [CH_W-1:0]   CFG_CH;
  logic [CW-1:0]     CFG_PERIOD;
  logic              CFG_ONESHOT;
  logic [NUM_CH-1:0] TICK;
  logic [NUM_CH-1:0] BUSY;

  int checks   = 0;
  int failures = 0;

  multi_tick_gen #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_WIDTH(CW), .DEFAULT_PERIOD(DEF)
  ) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .START(START), .SYNC(SYNC),
    .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_PERIOD(CFG_PERIOD),
    .CFG_ONESHOT(CFG_ONESHOT), .TICK(TICK), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: a periodic channel ticks on every P-th edge counted since its
  // phase restart; a one-shot ticks P edges after the START that armed it.
  logic [CW-1:0]     m_p   [NUM_CH];
  bit                m_os  [NUM_CH];
  bit                m_run [NUM_CH];
  int                m_ph  [NUM_CH];
  logic [NUM_CH-1:0] e_tick;
  logic [NUM_CH-1:0] e_busy;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_p[i]   <= CW'(DEF);
        m_os[i]  <= 1'b0;
        m_run[i] <= 1'b0;
        m_ph[i]  <= 0;
      end
      e_tick <= '0;
      e_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        int ph;
        bit run;
        bit tk;
        ph  = m_ph[i];
        run = m_run[i];
        tk  = 1'b0;
        if (CFG_WE && int'(CFG_CH) == i) begin
          m_p[i]  <= CFG_PERIOD;
          m_os[i] <= CFG_ONESHOT;
          ph  = 0;
          run = 1'b0;
        end else if (!EN[i]) begin
          ph  = 0;
          run = 1'b0;
        end else if (SYNC) begin
          ph = 0;
        end else if (m_p[i] == '0) begin
          ph = 0;
        end else if (!m_os[i]) begin
          tk = ((ph + 1) % int'(m_p[i])) == 0;
          ph = ph + 1;
        end else if (!run) begin
          if (START[i]) begin
            run = 1'b1;
            ph  = 0;
          end
        end else begin
          ph = ph + 1;
          if (ph == int'(m_p[i])) begin
            tk  = 1'b1;
            run = 1'b0;
            ph  = 0;
          end
        end
        m_ph[i]  <= ph;
        m_run[i] <= run;
        e_tick[i] <= tk;
        e_busy[i] <= run;
      end
    end
  end

  always @(negedge CLK) begin
    checks++;
    if (TICK !== e_tick || BUSY !== e_busy) begin
      failures++;
      $display("FAIL model_cmp t=%0t tick=%b busy=%b expected tick=%b busy=%b",
               $time, TICK, BUSY, e_tick, e_busy);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic cfg(input int ch, input int p, input bit os);
    CFG_WE      = 1'b1;
    CFG_CH      = CH_W'(ch);
    CFG_PERIOD  = CW'(p);
    CFG_ONESHOT = os;
    @(negedge CLK);
    CFG_WE      = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    EN = '0; START = '0; SYNC = 1'b0;
    CFG_WE = 1'b0; CFG_CH = '0; CFG_PERIOD = '0; CFG_ONESHOT = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("reset_tick", 32'(TICK), 32'h0);
    chk("reset_busy", 32'(BUSY), 32'h0);

    // Default period 10 on channel 0.
    EN = 4'b0001;
    for (int e = 0; e < 30; e++) begin
      @(negedge CLK);
      chk("periodic_default", 32'(TICK[0]), 32'((e == 9) || (e == 19) || (e == 29)));
    end

    // One-shot P=5 on channel 1; second START while running is ignored.
    cfg(1, 5, 1'b1);
    EN[1] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      START[1] = (e == 0) || (e == 2);
      @(negedge CLK);
      chk("oneshot_busy", 32'(BUSY[1]), 32'(e <= 4));
      chk("oneshot_tick", 32'(TICK[1]), 32'(e == 5));
    end
    START[1] = 1'b0;

    // Reprogram channel 0 from P=10 to P=3 while its counter sits at 6.
    cfg(0, 10, 1'b0);
    repeat (6) @(negedge CLK);
    cfg(0, 3, 1'b0);
    chk("reprog_k", 32'(TICK[0]), 32'h0);
    for (int j = 1; j < 8; j++) begin
      @(negedge CLK);
      chk("reprog_tick", 32'(TICK[0]), 32'((j == 3) || (j == 6)));
    end

    // SYNC restarts channel 0 (P=4) and channel 2 (P=6).
    cfg(0, 4, 1'b0);
    cfg(2, 6, 1'b0);
    EN[2] = 1'b1;
    repeat (7) @(negedge CLK);
    SYNC = 1'b1;
    @(negedge CLK);
    SYNC = 1'b0;
    chk("sync_k_ch0", 32'(TICK[0]), 32'h0);
    chk("sync_k_ch2", 32'(TICK[2]), 32'h0);
    for (int j = 1; j < 7; j++) begin
      @(negedge CLK);
      chk("sync_ch0", 32'(TICK[0]), 32'(j == 4));
      chk("sync_ch2", 32'(TICK[2]), 32'(j == 6));
    end

    // P=0 one-shot channel never ticks and ignores START.
    cfg(3, 0, 1'b1);
    EN[3] = 1'b1;
    START[3] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge CLK);
      chk("p0_tick", 32'(TICK[3]), 32'h0);
      chk("p0_busy", 32'(BUSY[3]), 32'h0);
    end
    START[3] = 1'b0;

    // P=1 periodic holds TICK high.
    cfg(2, 1, 1'b0);
    chk("p1_after_cfg", 32'(TICK[2]), 32'h0);
    for (int j = 0; j < 5; j++) begin
      @(negedge CLK);
      chk("p1_high", 32'(TICK[2]), 32'h1);
    end

    // Asynchronous reset between edges with a tick and a busy channel active.
    cfg(1, 20, 1'b1);
    START[1] = 1'b1;
    @(negedge CLK);
    START[1] = 1'b0;
    repeat (2) @(negedge CLK);
    chk("pre_reset_busy", 32'(BUSY[1]), 32'h1);
    chk("pre_reset_tick", 32'(TICK[2]), 32'h1);
    #1 RESET = 1'b1;
    #1;
    chk("async_reset_tick", 32'(TICK), 32'h0);
    chk("async_reset_busy", 32'(BUSY), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // All channels back at the default period; a write to channel NUM_CH is dropped.
    EN = '1;
    CFG_WE = 1'b1; CFG_CH = CH_W'(NUM_CH); CFG_PERIOD = CW'(3); CFG_ONESHOT = 1'b0;
    for (int e = 0; e < 21; e++) begin
      @(negedge CLK);
      CFG_WE = 1'b0;
      chk("post_reset_tick", 32'(TICK), (e == 9 || e == 19) ? 32'hF : 32'h0);
      chk("post_reset_busy", 32'(BUSY), 32'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 63) == 0) EN[c] = ~EN[c];
      end
      START       = NUM_CH'($urandom);
      SYNC        = ($urandom_range(0, 31) == 0);
      CFG_WE      = ($urandom_range(0, 15) == 0);
      CFG_CH      = CH_W'($urandom_range(0, NUM_CH));
      CFG_PERIOD  = CW'($urandom_range(0, 12));
      CFG_ONESHOT = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_tick_gen.md
# multi_tick_gen

Parametrised multi-channel periodic/one-shot tick generator for the remote-control datapath. Each of NUM_CH channels emits a registered one-cycle TICK pulse every programmed number of CLK cycles (periodic mode) or once after a START (one-shot mode). Channel 0 resets to the 10 Hz packet-send rate at a 100 MHz clock; the other channels serve display refresh, timeouts and debounce timing. Period and mode are runtime-reprogrammable through a single config write port.

## Interface
- NUM_CH, 4: number of independent channels, 1..16.
- CH_W, 2: width of CFG_CH; must be ≥ max(1, clog2(NUM_CH)).
- CNT_WIDTH, 25: width of period registers and counters.
- DEFAULT_PERIOD, 10000000: reset period of every channel in CLK cycles; must fit in CNT_WIDTH.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  NUM_CH  per-channel enable, level.
- START  in  NUM_CH  per-channel one-shot arm, sampled each edge.
- SYNC  in  1  global phase restart, sampled each edge.
- CFG_WE  in  1  config write strobe.
- CFG_CH  in  CH_W  channel index for the write.
- CFG_PERIOD  in  CNT_WIDTH  new period in cycles.
- CFG_ONESHOT  in  1  new mode: 1 = one-shot, 0 = periodic.
- TICK  out  NUM_CH  registered one-cycle pulse per channel.
- BUSY  out  NUM_CH  one-shot count in progress.

## Operation
- Per-channel state: period P (CNT_WIDTH bits), mode bit, counter C (CNT_WIDTH bits), one-shot state IDLE/RUN.
- Reset values:
  - P = DEFAULT_PERIOD.
  - Mode = periodic.
  - C = 0.
  - State = IDLE.
  - TICK = 0 and BUSY = 0 on all channels.
- Periodic mode, EN = 1, P ≥ 1:
  - Each edge: if C == P−1 then C ← 0 and TICK ← 1; otherwise C ← C+1 and TICK ← 0.
  - The period is exactly P cycles.
  - P = 1 gives TICK held high.
- Periodic mode, EN = 0 or P = 0: C ← 0, TICK ← 0.
- One-shot mode:
  - In IDLE, START = 1 with EN = 1 and P ≥ 1 moves the channel to RUN with C ← 0.
  - In RUN, C increments each edge. When C == P−1: TICK ← 1, C ← 0, state returns to IDLE.
  - START is ignored in RUN, when EN = 0, or when P = 0.
  - EN = 0 in RUN aborts to IDLE with C ← 0 and no tick.
- BUSY = 1 exactly while the state is RUN. BUSY is 0 in periodic mode.
- Config write:
  - CFG_WE = 1 with CFG_CH < NUM_CH loads P and mode into that channel.
  - The same edge clears C, forces the state to IDLE and TICK ← 0.
  - A write with CFG_CH ≥ NUM_CH is ignored.
- SYNC = 1: every channel's C ← 0 and TICK ← 0. The one-shot state is unchanged, so a RUN channel restarts its full count.
- Priority per channel, highest first: RESET, config write to this channel, EN = 0, SYNC, START, normal count.
- Arithmetic is unsigned CNT_WIDTH. The counter never exceeds P−1, so no wrap-around occurs.

## Timing
- TICK and BUSY are registered; there is no combinational path from any input to any output.
- Periodic latency:
  - First sampled-high EN edge is edge 0, with C = 0 beforehand.
  - The first tick is registered at edge P−1 and is visible for one cycle.
  - Later ticks occur every P edges.
- One-shot latency:
  - START is sampled at edge 0, and BUSY is high after edge 0.
  - TICK is registered at edge P, and BUSY falls at that same edge.
  - The earliest re-arm is START sampled at edge P+1.
- A config write at edge k: the channel counts with the new P from edge k+1, so the first periodic tick is at edge k+P.
- RESET asserted mid-count clears all outputs immediately, asynchronously. After release, channels restart from the reset values.

## Test plan
- **Periodic default with reduced period:** set DEFAULT_PERIOD = 10 and hold EN[0] = 1 from edge 0. TICK[0] must be high after edges 9, 19 and 29, and low on all other cycles.
- **One-shot:** write CH1 with P = 5 and one-shot mode, EN[1] = 1, pulse START[1] at edge 0.
  - BUSY[1] is high from edge 0 to edge 4 and low from edge 5.
  - TICK[1] is high after edge 5 only.
  - A second START at edge 2 has no effect.
- **Reprogram mid-count:** CH0 is running with P = 10 at C = 6 when it is written with P = 3 at edge k. Ticks occur at edges k+3 and k+6. The old-period tick must not occur.
- **SYNC and P = 0:**
  - With CH0 at P = 4 and CH2 at P = 6 running, SYNC at edge k makes both restart: next ticks at k+4 and k+6.
  - A channel with P = 0 never ticks and ignores START.
- **Reset and edge cases:**
  - Assert RESET mid-count between clock edges: TICK and BUSY go 0 immediately, and every P reads back as DEFAULT_PERIOD by its tick spacing.
  - A write with CFG_CH = NUM_CH changes no channel.
  - With P = 1 in periodic mode, TICK stays high continuously while EN = 1.
